multdiv_unit: RTL and testbench
===============================

Name: multdiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage.
- Consumes the same rs/rt operands as the ALU, alongside it, and produces the HI/LO pair for MULT, MULTU, DIV, DIVU, MFHI/MFLO, MTHI/MTLO.
- Radix-2, one bit per clock. The controller stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, WIDTH, iteration cycles per multiply or non-trivial divide.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  begin operation; sampled only while idle.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  rs operand (multiplicand / dividend).
- b  input  WIDTH  rt operand (multiplier / divisor).
- mthi  input  1  write wdata to HI; ignored while busy.
- mtlo  input  1  write wdata to LO; ignored while busy.
- wdata  input  WIDTH  data for MTHI/MTLO.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- dz  output  1  divide-by-zero flag, valid with done.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; busy=0, done=0, dz=0, hi=0, lo=0.
  - Counter and work registers are cleared.
  - An operation in flight is aborted with no partial result.
- States:
  - IDLE -> MUL on start with op[1]=0.
  - IDLE -> DIV on start with op[1]=1 and b!=0.
  - IDLE -> ZDIV on start with op[1]=1 and b==0.
  - MUL/DIV -> IDLE after ITER iteration cycles.
  - ZDIV -> IDLE after 1 cycle.
- Accept (edge E0):
  - Latch op and the sign flags.
  - For signed ops, latch the operand magnitudes (two's-complement absolute value); for unsigned ops, latch the raw values.
  - Load the counter with ITER; busy=1 from E0.
- MUL:
  - Shift-add each cycle on a 2*WIDTH accumulator: if the multiplier LSB is 1, add the multiplicand into the upper half; then shift right 1.
  - Carry out of the addition is kept; the add is WIDTH+1 bits.
- DIV:
  - Restoring division: shift the remainder:quotient pair left 1, trial-subtract the divisor (WIDTH+1 bits).
  - If the result is non-negative, keep it and set quotient bit 1; otherwise restore.
- Completion edge E32 (ITER edges after E0):
  - hi/lo are written; busy falls; done=1 for exactly the cycle after E32.
  - busy is therefore high for exactly ITER cycles.
- Result mapping:
  - MULT/MULTU: {hi,lo} = 64-bit product. Signed product is negated when a and b signs differ.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed quotient is negated when the signs differ; signed remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, dz=0 (falls out of the magnitude path; no special case).
- ZDIV:
  - Completes at E1: hi=a (raw), lo=0xFFFFFFFF, dz=1, done=1 for one cycle.
  - busy is high for 1 cycle.
- dz=0 on every other completion; dz holds its value until the next done.
- start while busy is ignored; op, a and b may change freely after E0.
- start and mthi/mtlo in the same idle cycle: start wins; mthi/mtlo are dropped.
- MTHI/MTLO while idle: the register is written at that edge; mthi and mtlo together write both.
- Writes issued while busy are dropped.
- hi/lo are stable (previous values) throughout busy.
- Back-to-back operation: start asserted in the done cycle is accepted; idle is re-entered at the completion edge.

Decomposition:
- Package multdiv_pkg:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state enum: IDLE, MUL, DIV, ZDIV.
  - Constants: WIDTH default, ZDIV_LO = all-ones.
- Single module, no sub-module.
- Absolute value and conditional negate are local functions shared by the MUL and DIV paths.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy high 32 cycles, then done; hi=0xFFFFFFFE, lo=0x00000001, dz=0.
- MULT 0xFFFFFFFD(-3)*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; second start during busy is ignored and the result is unchanged.
- DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1). DIVU 100/7 -> lo=14, hi=2.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> done after 1 cycle; hi=5, lo=0xFFFFFFFF, dz=1.
- MTHI 0x12345678 idle -> hi updates next edge; MTLO during busy -> lo unchanged; start+mtlo same cycle -> operation runs, lo not written by mtlo.
- reset asserted mid-MULT (cycle 10), asynchronously between edges -> busy=0, done=0, hi=lo=0 immediately; next start completes normally in 32 cycles.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
package multdiv_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] ZDIV = 2'd3;

    localparam logic [WIDTH_DEF-1:0] ZDIV_LO = '1;

endpackage

// File: rtl/multdiv_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO writes.
// ITER cycles per multiply/divide, 1 cycle for divide-by-zero; the pipeline stalls on busy.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ITER  = WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITER + 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opa;
    logic [2*WIDTH-1:0] acc;
    logic               neg_q;
    logic               neg_r;

    logic               sgn;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    function automatic logic [WIDTH-1:0] absv(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] x, input logic n);
        return n ? -x : x;
    endfunction

    assign busy  = (state != IDLE);
    assign sgn   = (op == OP_MULT) || (op == OP_DIV);
    assign a_mag = absv(a, sgn);
    assign b_mag = absv(b, sgn);

    // acc holds {carry-free upper, multiplier} for MUL and {remainder, quotient} for DIV
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opa : '0)};
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opa};
        acc_nxt   = acc;
        if (state == MUL) begin
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        end else if (state == DIV) begin
            if (div_trial[WIDTH])
                acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
            else
                acc_nxt = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
        // A 2*WIDTH negate is the low-half negate plus a borrow into the high half
        res_lo = cneg(acc_nxt[WIDTH-1:0], neg_q);
        if (state == MUL)
            res_hi = cneg(acc_nxt[2*WIDTH-1:WIDTH], neg_q)
                   - WIDTH'(neg_q && (acc_nxt[WIDTH-1:0] != '0));
        else
            res_hi = cneg(acc_nxt[2*WIDTH-1:WIDTH], neg_r);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            opa   <= '0;
            acc   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            done  <= 1'b0;
            dz    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= CW'(ITER);
                        if (!op[1]) begin
                            state <= MUL;
                            opa   <= a_mag;
                            acc   <= {{WIDTH{1'b0}}, b_mag};
                            neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r <= 1'b0;
                        end else if (b != '0) begin
                            state <= DIV;
                            opa   <= b_mag;
                            acc   <= {{WIDTH{1'b0}}, a_mag};
                            neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r <= sgn && a[WIDTH-1];
                        end else begin
                            state <= ZDIV;
                            acc   <= {a, {WIDTH{1'b0}}};
                        end
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                MUL, DIV: begin
                    acc <= acc_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        dz    <= 1'b0;
                        hi    <= res_hi;
                        lo    <= res_lo;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    dz    <= 1'b1;
                    hi    <= acc[2*WIDTH-1:WIDTH];
                    lo    <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: directed vectors push expected HI/LO/dz/busy-length.
module tb_multdiv_unit;
    import multdiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        mthi  = 1'b0;
    logic        mtlo  = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    multdiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
        int          tag;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   ndone  = 0;
    int   bcnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare on every done pulse, also the busy length preceding it
    always @(negedge clock) begin
        if (reset) begin
            bcnt = 0;
        end else begin
            if (done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1, expected no pending operation");
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("op%0d_hi", e.tag), hi, e.hi);
                    chk($sformatf("op%0d_lo", e.tag), lo, e.lo);
                    chk($sformatf("op%0d_dz", e.tag), {31'b0, dz}, {31'b0, e.dz});
                    chk($sformatf("op%0d_busy_cycles", e.tag), bcnt, e.cyc);
                end
                bcnt = 0;
                ndone++;
            end
            if (busy) bcnt++;
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit push, input logic [31:0] eh, input logic [31:0] el,
                         input logic edz, input int cyc, input int tag);
        exp_t t;
        if (push) begin
            t.hi = eh; t.lo = el; t.dz = edz; t.cyc = cyc; t.tag = tag;
            sbq.push_back(t);
        end
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clock); #1;
        start = 1'b0; a = 32'h5a5a_a5a5; b = 32'h0f0f_f0f0;
    endtask

    task automatic wait_done(input int tag);
        int n0 = ndone;
        int k  = 0;
        while (ndone == n0 && k < 100) begin
            @(negedge clock); #1;
            k++;
        end
        if (ndone == n0) begin
            checks++;
            errors++;
            $display("FAIL op%0d_timeout: got no done in 100 cycles, expected done", tag);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clock); #1; end
    endtask

    initial begin
        idle(2);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_dz",   {31'b0, dz},   32'd0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        reset = 1'b0;
        idle(1);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 32, 1);
        wait_done(1);
        idle(1);

        // Ignored second start plus a dropped MTLO while busy
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 32, 2);
        idle(3);
        start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd2; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
        idle(1);
        start = 1'b0; mtlo = 1'b0;
        idle(1);
        chk("busy_mtlo_lo", lo, 32'h0000_0001);
        chk("busy_hi_stable", hi, 32'hFFFF_FFFE);
        wait_done(2);
        idle(1);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32, 3);
        wait_done(3);

        // Back-to-back: the next start lands in the done cycle
        issue(OP_DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0, 32, 4);
        wait_done(4);
        issue(OP_MULTU, 32'd6, 32'd7, 1, 32'd0, 32'd42, 1'b0, 32, 5);
        wait_done(5);
        idle(1);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 32'h8000_0000, 1'b0, 32, 6);
        wait_done(6);
        idle(1);

        issue(OP_DIVU, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1'b1, 1, 7);
        wait_done(7);
        idle(3);
        chk("dz_held", {31'b0, dz}, 32'd1);

        mthi = 1'b1; wdata = 32'h1234_5678;
        idle(1);
        mthi = 1'b0;
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_lo_kept", lo, 32'hFFFF_FFFF);

        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0BAD_F00D;
        idle(1);
        mthi = 1'b0; mtlo = 1'b0;
        chk("mtboth_hi", hi, 32'h0BAD_F00D);
        chk("mtboth_lo", lo, 32'h0BAD_F00D);

        // start wins over a same-cycle MTLO
        mtlo = 1'b1; wdata = 32'hABCD_EF01;
        issue(OP_MULTU, 32'd3, 32'd5, 1, 32'd0, 32'd15, 1'b0, 32, 8);
        mtlo = 1'b0;
        chk("start_mtlo_lo", lo, 32'h0BAD_F00D);
        chk("start_busy", {31'b0, busy}, 32'd1);
        wait_done(8);
        idle(1);

        mthi = 1'b1; wdata = 32'hCAFE_0001;
        idle(1);
        mthi = 1'b0;

        // Asynchronous abort between clock edges
        issue(OP_MULT, 32'h1111_1111, 32'd3, 0, 32'd0, 32'd0, 1'b0, 0, 9);
        idle(9);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        @(negedge clock); #1;
        reset = 1'b0;
        idle(1);

        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 1, 32'd1, 32'd0, 1'b0, 32, 10);
        wait_done(10);
        idle(3);

        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
